// File: rtl/apb_spi_slave_pkg.sv
// Shared constants and types for the APB SPI target: register offsets,
// STATUS bit positions and the core state encoding.
package apb_spi_slave_pkg;
  localparam logic [2:0] OFS_DATA   = 3'd0;
  localparam logic [2:0] OFS_CTRL   = 3'd1;
  localparam logic [2:0] OFS_CFG    = 3'd2;
  localparam logic [2:0] OFS_STATUS = 3'd4;
  localparam logic [2:0] OFS_IM     = 3'd5;

  localparam int ST_RXV  = 0;
  localparam int ST_TXE  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_BUSY = 3;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} core_state_e;
endpackage

// File: rtl/apb_spi_slave_core.sv
// SPI target core: oversamples SCLK/SSn/MOSI in the PCLK domain and runs
// the frame FSM with the RX and TX shift registers.
module spi_slave_core
  import apb_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  en,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  SCLK,
  input  logic                  SSn,
  input  logic                  MOSI,
  input  logic                  tx_avail,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  ss_active,
  output logic                  MISO
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, ssn_sync, mosi_sync;
  logic sclk_d, ssn_d;
  logic sclk_s, ssn_s, mosi_s;

  core_state_e state, state_nxt;
  logic cpol_q, cpha_q, skip;
  logic [CW-1:0] bitcnt;
  logic [DATA_WIDTH-1:0] rx_shift, tx_shift;

  logic sclk_rise, sclk_fall, lead, trail, sample_edge, shift_edge;
  logic ssn_fall, ssn_rise, start, run, sample_ev, shift_ev, done, load;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      sclk_sync <= '0;
      ssn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ssn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], SSn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ssn_d     <= ssn_s;
    end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign ssn_fall    = ssn_d & ~ssn_s;
  assign ssn_rise    = ~ssn_d & ssn_s;
  // Edge roles come from the mode captured at frame entry, not the live CFG.
  assign lead        = cpol_q ? sclk_fall : sclk_rise;
  assign trail       = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign shift_edge  = cpha_q ? lead : trail;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en && ssn_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: if (!en || ssn_rise) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign start     = (state == S_IDLE) && (state_nxt == S_ACTIVE);
  assign run       = (state == S_ACTIVE) && (state_nxt == S_ACTIVE);
  assign sample_ev = run && sample_edge;
  assign shift_ev  = run && shift_edge;
  assign done      = sample_ev && (bitcnt == LAST);
  assign load      = start || done;
  assign tx_load   = load && tx_avail;
  assign rx_byte   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign rx_valid  = done;
  assign busy      = (state == S_ACTIVE);
  assign ss_active = ~ssn_s;
  assign MISO      = tx_shift[DATA_WIDTH-1];

  // skip swallows the one shift edge that would otherwise clobber a freshly
  // loaded MSB: the first leading edge in CPHA=1, the 8th trailing in CPHA=0.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      skip     <= 1'b0;
      bitcnt   <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (start) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        skip   <= cpha;
        bitcnt <= '0;
      end
      if (load) tx_shift <= tx_avail ? tx_byte : '0;
      else if (shift_ev) begin
        if (skip) skip <= 1'b0;
        else      tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_ev) begin
        rx_shift <= rx_byte;
        bitcnt   <= done ? '0 : bitcnt + 1'b1;
        if (done) skip <= 1'b1;
      end
    end
endmodule

// File: rtl/apb_spi_slave.sv
// APB-attached SPI target: register file, RX/TX holding registers, flags
// and IRQ around the oversampling SPI core.
module apb_spi_slave
  import apb_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        SCLK,
  input  logic        SSn,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        IRQ
);
  logic [2:0] ofs;
  logic wr, rd, rd_data, ovr_set, ovr_clr;
  logic en, cpol, cpha, txe, rxv, ovr, irq;
  logic [1:0] im;
  logic [DATA_WIDTH-1:0] txdata, rxdata, rx_byte;
  logic tx_load, rx_valid, busy, ss_active;
  logic unused_bits;

  assign ofs     = PADDR[4:2];
  assign wr      = PSEL & PENABLE & PWRITE;
  assign rd      = PSEL & PENABLE & ~PWRITE;
  assign rd_data = rd && (ofs == OFS_DATA);
  // A read landing on the completion cycle counts as having emptied RXDATA.
  assign ovr_set = rx_valid && rxv && !rd_data;
  assign ovr_clr = wr && (ofs == OFS_STATUS) && PWDATA[ST_OVR];
  assign PREADY  = 1'b1;
  assign MISO_OE = en & ss_active;
  assign IRQ     = irq;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:DATA_WIDTH]};

  spi_slave_core #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(DATA_WIDTH)) u_core (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .en        (en),
    .cpol      (cpol),
    .cpha      (cpha),
    .SCLK      (SCLK),
    .SSn       (SSn),
    .MOSI      (MOSI),
    .tx_avail  (~txe),
    .tx_byte   (txdata),
    .tx_load   (tx_load),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .ss_active (ss_active),
    .MISO      (MISO)
  );

  always_comb begin
    PRDATA = '0;
    case (ofs)
      OFS_DATA:   PRDATA[DATA_WIDTH-1:0] = rxdata;
      OFS_CTRL:   PRDATA[0] = en;
      OFS_CFG:    PRDATA[1:0] = {cpha, cpol};
      OFS_STATUS: begin
        PRDATA[ST_RXV]  = rxv;
        PRDATA[ST_TXE]  = txe;
        PRDATA[ST_OVR]  = ovr;
        PRDATA[ST_BUSY] = busy;
      end
      OFS_IM:     PRDATA[1:0] = im;
      default:    PRDATA = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      en     <= 1'b0;
      cpol   <= 1'b0;
      cpha   <= 1'b0;
      im     <= '0;
      txdata <= '0;
      txe    <= 1'b1;
      rxdata <= '0;
      rxv    <= 1'b0;
      ovr    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && ofs == OFS_CTRL) en <= PWDATA[0];
      if (wr && ofs == OFS_CFG) {cpha, cpol} <= PWDATA[1:0];
      if (wr && ofs == OFS_IM) im <= PWDATA[1:0];
      // A CPU write beats the core's consume: old byte goes out, new one waits.
      if (wr && ofs == OFS_DATA) begin
        txdata <= PWDATA[DATA_WIDTH-1:0];
        txe    <= 1'b0;
      end else if (tx_load) txe <= 1'b1;
      if (rx_valid && !ovr_set) begin
        rxdata <= rx_byte;
        rxv    <= 1'b1;
      end else if (rd_data) rxv <= 1'b0;
      if (ovr_set)      ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;
      irq <= (im[0] & rxv) | (im[1] & ovr);
    end
endmodule
